// File: rtl/fix_pkg.sv
// Shared constants and types for the FIX message-creation path.
// Trailer byte values, checksum FSM states and an ASCII digit helper.
package fix_pkg;

   localparam logic [7:0] FIX_SOH        = 8'h01;
   localparam logic [7:0] ASCII_ZERO     = 8'h30;
   localparam logic [7:0] ASCII_EQ       = 8'h3D;
   localparam logic [7:0] CHKSUM_TAG_HI  = 8'h31;  // '1' of tag 10
   localparam logic [7:0] CHKSUM_TAG_LO  = 8'h30;  // '0' of tag 10
   localparam int         TRAILER_LEN    = 7;

   typedef enum logic [1:0] {
      IDLE,
      PASS,
      CONV,
      TRAIL
   } checksum_state_t;

   function automatic logic [7:0] bcd_to_ascii(input logic [3:0] digit);
      return ASCII_ZERO + {4'h0, digit};
   endfunction

endpackage

// File: rtl/bin8_to_bcd3.sv
// Sequential double-dabble: 8-bit binary to three BCD digits, one bit per cycle.
// done_o is high during the final iteration; the digits are valid from the next cycle.
module bin8_to_bcd3 #(
   parameter int CONV_CYCLES = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start_i,
   input  logic [7:0] bin_i,
   output logic [3:0] hundreds_o,
   output logic [3:0] tens_o,
   output logic [3:0] units_o,
   output logic       done_o
);

   localparam int CNT_W = $clog2(CONV_CYCLES + 1);

   logic [7:0]       shift_q, shift_d;
   logic [11:0]      bcd_q, bcd_d, bcd_adj;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   // NOTE: every value written here gets a default first, so no latch is inferred.
   always_comb begin
      bcd_adj = bcd_q;
      for (int i = 0; i < 3; i++) begin
         if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
      shift_d = shift_q;
      bcd_d   = bcd_q;
      cnt_d   = cnt_q;
      if (start_i) begin
         shift_d = bin_i;
         bcd_d   = '0;
         cnt_d   = CNT_W'(CONV_CYCLES);
      end else if (cnt_q != '0) begin
         {bcd_d, shift_d} = {bcd_adj[10:0], shift_q, 1'b0};
         cnt_d            = cnt_q - CNT_W'(1);
      end
   end

   // NOTE: sequential state is updated with non-blocking assignments only.
   always_ff @(posedge clk) begin
      if (rst) begin
         shift_q <= '0;
         bcd_q   <= '0;
         cnt_q   <= '0;
      end else begin
         shift_q <= shift_d;
         bcd_q   <= bcd_d;
         cnt_q   <= cnt_d;
      end
   end

   assign hundreds_o = bcd_q[11:8];
   assign tens_o     = bcd_q[7:4];
   assign units_o    = bcd_q[3:0];
   assign done_o     = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/fix_checksum_trailer.sv
// Passes FIX header/body bytes through a registered stage, sums them mod 256
// and appends the "10=ddd<SOH>" trailer once the last body byte has gone by.
module fix_checksum_trailer
   import fix_pkg::*;
#(
   parameter int DATA_WIDTH  = 8,
   parameter int CONV_CYCLES = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start_i,
   input  logic                  in_valid_i,
   input  logic [DATA_WIDTH-1:0] in_byte_i,
   input  logic                  in_last_i,
   output logic                  in_ready_o,
   output logic                  out_valid_o,
   output logic [DATA_WIDTH-1:0] out_byte_o,
   output logic                  out_last_o,
   input  logic                  out_ready_i,
   output logic [7:0]            checksum_o,
   output logic                  busy_o,
   output logic                  done_o
);

   checksum_state_t       state_q, state_d;
   logic [7:0]            sum_q, sum_d, sum_add;
   logic [7:0]            chk_q, chk_d;
   logic [DATA_WIDTH-1:0] out_byte_q, out_byte_d, load_byte;
   logic                  out_valid_q, out_valid_d, out_last_q, out_last_d;
   logic [2:0]            trail_idx_q, trail_idx_d;
   logic                  done_q, done_d;
   logic                  load, load_last, out_free, out_xfer, in_xfer, conv_start, conv_done;
   logic [3:0]            hundreds, tens, units;
   logic [7:0]            trail_byte;

   assign out_free   = !out_valid_q || out_ready_i;
   assign out_xfer   = out_valid_q && out_ready_i;
   assign in_ready_o = (state_q == PASS) && out_free;
   assign in_xfer    = in_valid_i && in_ready_o;
   assign sum_add    = sum_q + in_byte_i;
   // The converter is loaded with the final sum on the same edge the last byte is taken.
   assign conv_start = in_xfer && in_last_i;

   bin8_to_bcd3 #(.CONV_CYCLES(CONV_CYCLES)) u_bcd (
      .clk       (clk),
      .rst       (rst),
      .start_i   (conv_start),
      .bin_i     (sum_add),
      .hundreds_o(hundreds),
      .tens_o    (tens),
      .units_o   (units),
      .done_o    (conv_done)
   );

   always_comb begin
      case (trail_idx_q)
         3'd0:    trail_byte = CHKSUM_TAG_HI;
         3'd1:    trail_byte = CHKSUM_TAG_LO;
         3'd2:    trail_byte = ASCII_EQ;
         3'd3:    trail_byte = bcd_to_ascii(hundreds);
         3'd4:    trail_byte = bcd_to_ascii(tens);
         3'd5:    trail_byte = bcd_to_ascii(units);
         default: trail_byte = FIX_SOH;
      endcase
   end

   always_comb begin
      state_d     = state_q;
      sum_d       = sum_q;
      chk_d       = chk_q;
      trail_idx_d = trail_idx_q;
      done_d      = 1'b0;
      load        = 1'b0;
      load_byte   = trail_byte;
      load_last   = 1'b0;
      case (state_q)
         IDLE: begin
            if (start_i) begin
               sum_d       = '0;
               trail_idx_d = '0;
               state_d     = PASS;
            end
         end
         PASS: begin
            if (in_xfer) begin
               load      = 1'b1;
               load_byte = in_byte_i;
               sum_d     = sum_add;
               if (in_last_i) state_d = CONV;
            end
         end
         CONV: begin
            // Tag byte '1' is queued on the last conversion cycle so it leads at T+9.
            if (conv_done) begin
               chk_d   = sum_q;
               state_d = TRAIL;
               if (out_free) begin
                  load        = 1'b1;
                  trail_idx_d = 3'd1;
               end
            end
         end
         TRAIL: begin
            if (done_q) begin
               state_d = IDLE;
            end else if ((trail_idx_q < 3'(TRAILER_LEN)) && out_free) begin
               load        = 1'b1;
               load_last   = (trail_idx_q == 3'(TRAILER_LEN - 1));
               trail_idx_d = trail_idx_q + 3'd1;
            end
            if (out_xfer && out_last_q) done_d = 1'b1;
         end
         default: state_d = IDLE;
      endcase

      out_byte_d  = out_byte_q;
      out_valid_d = out_valid_q;
      out_last_d  = out_last_q;
      if (load) begin
         out_byte_d  = load_byte;
         out_valid_d = 1'b1;
         out_last_d  = load_last;
      end else if (out_xfer) begin
         out_valid_d = 1'b0;
         out_last_d  = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         sum_q       <= '0;
         chk_q       <= '0;
         out_byte_q  <= '0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
         trail_idx_q <= '0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         sum_q       <= sum_d;
         chk_q       <= chk_d;
         out_byte_q  <= out_byte_d;
         out_valid_q <= out_valid_d;
         out_last_q  <= out_last_d;
         trail_idx_q <= trail_idx_d;
         done_q      <= done_d;
      end
   end

   assign out_valid_o = out_valid_q;
   assign out_byte_o  = out_byte_q;
   assign out_last_o  = out_last_q;
   assign checksum_o  = chk_q;
   assign busy_o      = (state_q != IDLE);
   assign done_o      = done_q;

endmodule

// File: tb/tb_fix_checksum_trailer.sv
// Self-checking bench for fix_checksum_trailer: message table plus scoreboard of
// expected output bytes, with backpressure, ignored-start and mid-trailer reset cases.
module tb_fix_checksum_trailer;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start_i = 1'b0;
   logic       in_valid_i = 1'b0;
   logic [7:0] in_byte_i = 8'h00;
   logic       in_last_i = 1'b0;
   logic       in_ready_o;
   logic       out_valid_o;
   logic [7:0] out_byte_o;
   logic       out_last_o;
   logic       out_ready_i = 1'b1;
   logic [7:0] checksum_o;
   logic       busy_o;
   logic       done_o;

   fix_checksum_trailer #(.DATA_WIDTH(8), .CONV_CYCLES(8)) dut (
      .clk        (clk),
      .rst        (rst),
      .start_i    (start_i),
      .in_valid_i (in_valid_i),
      .in_byte_i  (in_byte_i),
      .in_last_i  (in_last_i),
      .in_ready_o (in_ready_o),
      .out_valid_o(out_valid_o),
      .out_byte_o (out_byte_o),
      .out_last_o (out_last_o),
      .out_ready_i(out_ready_i),
      .checksum_o (checksum_o),
      .busy_o     (busy_o),
      .done_o     (done_o)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [2:0]  len;
      logic [31:0] bytes;    // byte i at bytes[8*i +: 8]
      logic [7:0]  exp_sum;
   } vec_t;

   vec_t       vecs [7];
   logic [8:0] exp_q [$];    // {last, byte}
   int         n_checks = 0;
   int         n_err = 0;
   int         done_cnt = 0;
   bit         bp_mode = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Trailer model: decimal digits by division, independent of the shift-add-3 hardware.
   task automatic push_trailer(input logic [7:0] sum);
      int s;
      s = int'(sum);
      exp_q.push_back(9'h031);
      exp_q.push_back(9'h030);
      exp_q.push_back(9'h03D);
      exp_q.push_back({1'b0, 8'(8'h30 + s / 100)});
      exp_q.push_back({1'b0, 8'(8'h30 + (s / 10) % 10)});
      exp_q.push_back({1'b0, 8'(8'h30 + s % 10)});
      exp_q.push_back(9'h101);
   endtask

   // Downstream ready: held high unless the current message runs with backpressure.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         out_ready_i = bp_mode ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   // Output monitor: pops the scoreboard on each transfer and checks stall stability.
   logic [8:0] held = '0;
   bit         stalled = 1'b0;
   always @(negedge clk) begin
      if (rst) begin
         stalled = 1'b0;
      end else begin
         if (stalled) begin
            check("stall_valid", 32'(out_valid_o), 32'd1);
            check("stall_hold", 32'({out_last_o, out_byte_o}), 32'(held));
         end
         if (out_valid_o && out_ready_i) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               n_err++;
               $display("FAIL unexpected_output: got %0h expected nothing at %0t",
                        {out_last_o, out_byte_o}, $time);
            end else begin
               check("out_byte", 32'({out_last_o, out_byte_o}), 32'(exp_q.pop_front()));
            end
         end
         if (done_o) done_cnt++;
         stalled = out_valid_o && !out_ready_i;
         held    = {out_last_o, out_byte_o};
      end
   end

   task automatic drive_body(input logic [31:0] bytes, input int len, input bit glitch);
      bit acc;
      int waitc;
      @(posedge clk);
      #1;
      start_i = 1'b1;
      @(posedge clk);
      #1;
      start_i = 1'b0;
      check("busy_after_start", 32'(busy_o), 32'd1);
      for (int i = 0; i < len; i++) begin
         in_valid_i = 1'b1;
         in_byte_i  = bytes[8*i +: 8];
         in_last_i  = (i == len - 1);
         start_i    = glitch && (i == 1);
         exp_q.push_back({1'b0, bytes[8*i +: 8]});
         acc   = 1'b0;
         waitc = 0;
         while (!acc && waitc < 100) begin
            @(negedge clk);
            acc = in_ready_o;
            if (!acc) waitc++;
         end
         check("in_ready_seen", 32'(acc), 32'd1);
         @(posedge clk);
         #1;
      end
      in_valid_i = 1'b0;
      in_last_i  = 1'b0;
      start_i    = 1'b0;
   endtask

   task automatic send_msg(input logic [31:0] bytes, input int len, input logic [7:0] exp_sum,
                           input bit bp, input bit glitch);
      int waitc;
      int done_before;
      bp_mode     = bp;
      done_before = done_cnt;
      drive_body(bytes, len, glitch);
      push_trailer(exp_sum);
      // Now one cycle past the edge that took the last byte (T+1).
      if (!bp) begin
         repeat (7) @(posedge clk);
         #1;
         check("conv_no_early_trailer", 32'(out_valid_o), 32'd0);
         check("busy_in_conv", 32'(busy_o), 32'd1);
         @(posedge clk);
         #1;
         check("checksum_at_t9", 32'(checksum_o), 32'(exp_sum));
         check("trailer_valid_at_t9", 32'(out_valid_o), 32'd1);
         start_i = glitch;
         @(posedge clk);
         #1;
         start_i = 1'b0;
         repeat (6) @(posedge clk);
         #1;
         check("done_at_t16", 32'(done_o), 32'd1);
         @(posedge clk);
         #1;
         check("done_single_cycle", 32'(done_o), 32'd0);
         check("idle_after_done", 32'(busy_o), 32'd0);
      end else begin
         waitc = 0;
         while (!done_o && waitc < 500) begin
            @(posedge clk);
            #1;
            waitc++;
         end
         check("done_within_bound", 32'(done_o), 32'd1);
         @(posedge clk);
         #1;
      end
      bp_mode = 1'b0;
      check("checksum", 32'(checksum_o), 32'(exp_sum));
      check("done_count", 32'(done_cnt - done_before), 32'd1);
      check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
   endtask

   initial begin
      int done_before;
      vecs[0] = '{len: 3'd3, bytes: 32'h0001_4241, exp_sum: 8'h84};
      vecs[1] = '{len: 3'd3, bytes: 32'h00FF_FFFF, exp_sum: 8'hFD};
      vecs[2] = '{len: 3'd1, bytes: 32'h0000_0000, exp_sum: 8'h00};
      vecs[3] = '{len: 3'd4, bytes: 32'h4030_2010, exp_sum: 8'hA0};
      vecs[4] = '{len: 3'd1, bytes: 32'h0000_0063, exp_sum: 8'h63};
      vecs[5] = '{len: 3'd2, bytes: 32'h0000_3232, exp_sum: 8'h64};
      vecs[6] = '{len: 3'd2, bytes: 32'h0000_8580, exp_sum: 8'h05};

      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("rst_out_valid", 32'(out_valid_o), 32'd0);
      check("rst_out_last", 32'(out_last_o), 32'd0);
      check("rst_out_byte", 32'(out_byte_o), 32'd0);
      check("rst_in_ready", 32'(in_ready_o), 32'd0);
      check("rst_busy", 32'(busy_o), 32'd0);
      check("rst_done", 32'(done_o), 32'd0);
      check("rst_checksum", 32'(checksum_o), 32'd0);
      rst = 1'b0;

      // Input offered in IDLE must be ignored.
      in_valid_i = 1'b1;
      in_byte_i  = 8'h55;
      repeat (2) @(posedge clk);
      #1;
      check("idle_in_ready", 32'(in_ready_o), 32'd0);
      check("idle_no_output", 32'(out_valid_o), 32'd0);
      in_valid_i = 1'b0;

      for (int i = 0; i < 7; i++) begin
         send_msg(vecs[i].bytes, int'(vecs[i].len), vecs[i].exp_sum, 1'b0, 1'b0);
      end
      for (int i = 0; i < 4; i++) begin
         send_msg(vecs[i].bytes, int'(vecs[i].len), vecs[i].exp_sum, 1'b1, 1'b0);
      end
      send_msg(vecs[0].bytes, int'(vecs[0].len), vecs[0].exp_sum, 1'b0, 1'b1);

      // Reset while the hundreds digit (trailer index 3) is on the output.
      done_before = done_cnt;
      drive_body(32'h0001_4241, 3, 1'b0);
      push_trailer(8'h84);
      repeat (11) @(posedge clk);
      #1;
      check("abort_at_idx3", 32'({out_last_o, out_byte_o}), 32'h031);
      rst = 1'b1;
      exp_q.delete();
      @(posedge clk);
      #1;
      rst = 1'b0;
      check("abort_out_dropped", 32'(out_valid_o), 32'd0);
      check("abort_idle", 32'(busy_o), 32'd0);
      repeat (20) @(posedge clk);
      #1;
      check("abort_no_done", 32'(done_cnt - done_before), 32'd0);
      send_msg(32'h0000_0001, 1, 8'h01, 1'b0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/fix_checksum_trailer.md
# fix_checksum_trailer

- Streaming stage directly downstream of body-length generation in the FIX message-creation path.
- Passes every header/body byte through a one-entry registered output stage and accumulates the FIX checksum (sum of all bytes, mod 256).
- After the final body byte, converts the sum to three ASCII decimal digits with a sequential shift-add-3 converter and appends the trailer "10=ddd<SOH>" to the stream.
- Frames the message end for the transmit MAC/FIFO.

## Interface

Reset is synchronous, active-high; one clock.

Parameters:
- DATA_WIDTH, 8, stream byte width (only 8 supported)
- CONV_CYCLES, 8, binary-to-BCD iterations (one per sum bit)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous active-high reset
- start_i  in  1  begin new message; honoured only in IDLE
- in_valid_i  in  1  input byte valid
- in_byte_i  in  8  input byte
- in_last_i  in  1  marks final body byte (the SOH before tag 10)
- in_ready_o  out  1  input handshake ready
- out_valid_o  out  1  output byte valid
- out_byte_o  out  8  output byte
- out_last_o  out  1  high with trailer SOH only
- out_ready_i  in  1  downstream ready
- checksum_o  out  8  binary checksum; stable from end of CONV until next accepted start_i
- busy_o  out  1  high in every state except IDLE
- done_o  out  1  one-cycle pulse after the trailer SOH handshake

## Operation

Handshakes:
- Input transfer: in_valid_i && in_ready_o.
- Output transfer: out_valid_o && out_ready_i.

States: IDLE, PASS, CONV, TRAIL.

- IDLE
  - in_ready_o = 0.
  - start_i: sum <= 0, go to PASS.
  - Input bytes are ignored.
- PASS
  - in_ready_o = !out_valid_o || out_ready_i.
  - On input transfer: output register <= in_byte_i with out_last_o = 0, and sum <= sum + in_byte_i (8-bit wrap).
  - Transfer with in_last_i = 1: go to CONV; the sum includes this byte.
- CONV
  - in_ready_o = 0.
  - 8-cycle double-dabble of the sum into 3 BCD digits (adjust each digit ≥5 by +3, then shift left).
  - The output register keeps draining independently.
  - After cycle 8: latch checksum_o, go to TRAIL.
- TRAIL
  - Index 0..6 emits '1'(0x31), '0'(0x30), '='(0x3D), hundreds+0x30, tens+0x30, units+0x30, SOH(0x01).
  - A byte is loaded into the output register only when it is free or being drained that cycle.
  - out_last_o = 1 with SOH only.
  - After the SOH transfer: done_o pulses, go to IDLE.
- start_i outside IDLE is ignored; it does not clear the sum.
- Input byte values are not checked; any value, including 0x00 and 0xFF, is summed.
- Sum wraps: 0xFF+0xFF+0xFF → 0xFD (253).
- Reset in any state, including mid-trailer or mid-CONV:
  - Aborts the message and returns to IDLE.
  - Drops any held output byte.
  - No done_o is produced.

## Timing

- Reset values:
  - state = IDLE; sum, checksum_o, out_byte_o, BCD registers = 0.
  - out_valid_o, out_last_o, in_ready_o, busy_o, done_o = 0.
- Pass latency is 1 cycle: a byte accepted at cycle T is on out_byte_o at T+1.
- Last body byte accepted at T:
  - CONV occupies T+1..T+8.
  - checksum_o is valid at T+9.
  - The first trailer byte is valid no earlier than T+9.
- With out_ready_i held high, the trailer occupies 7 consecutive cycles, T+9..T+15, and done_o pulses at T+16.
- With out_ready_i held low, out_valid_o/out_byte_o/out_last_o stay stable until the transfer; nothing is dropped or duplicated.
- The earliest start_i acceptance is the cycle after done_o.

## Structure

Shared package fix_pkg holds:
- FIX_SOH = 8'h01, ASCII_ZERO = 8'h30, ASCII_EQ = 8'h3D
- checksum tag constants '1','0'
- checksum_state_t enum {IDLE, PASS, CONV, TRAIL}
- TRAILER_LEN = 7

Sub-module bin8_to_bcd3 holds the sequential 8-cycle double-dabble:
- Inputs: start, 8-bit binary.
- Outputs: three 4-bit digits, done.
- Reusable for other 3-digit fields (e.g. message sequence numbers).

The top level holds the FSM, accumulator, output register and trailer mux.

## Test plan

- Bytes 0x41, 0x42, 0x01 (last), out_ready_i = 1:
  - Output is 41 42 01 31 30 3D 31 33 32 01.
  - checksum_o = 0x84 (132); out_last_o only on the final 01; done_o fires once.
- Three bytes 0xFF (last on third):
  - checksum_o = 0xFD.
  - Trailer is "10=253" followed by SOH (31 30 3D 32 35 33 01).
- Single byte 0x00 with in_last_i: trailer "10=000" followed by SOH (digits 0x30 0x30 0x30).
- out_ready_i toggling pseudo-randomly during PASS and TRAIL:
  - Output byte sequence is identical to the no-backpressure run.
  - Held bytes are stable while stalled.
- start_i pulsed during PASS and during TRAIL: ignored; the sum and trailer are unchanged from the reference value.
- rst asserted at trailer index 3, then a new message 0x01 (last):
  - The aborted message produces no done_o.
  - The new message yields the trailer "10=001" followed by SOH.
